// File: rtl/pipe_hazard_ctrl.sv
// Purpose : hazard/stall controller for a 5-stage pipeline (load-use, branch flush, MDU stall, halt).
// Latency : control outputs are combinational from state+inputs; state/counters update on rising clk.
// Backpr. : stalls by dropping pc_en/ifid_en and inserting ID/EX bubbles; no upstream handshake.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_rs, id_rt               IF/ID source registers
//   id_use_rs, id_use_rt       IF/ID instruction reads rs / rt
//   idex_mem_read, idex_rd     ID/EX is a load, and its destination
//   ex_branch_taken            branch/jump resolved taken in EX
//   id_mdu_op, id_halt         IF/ID is a multiply/divide, or a halt
//   pc_en, ifid_en             PC write enable, IF/ID enable
//   ifid_flush, idex_bubble    clear IF/ID, insert NOP into ID/EX
//   mdu_start                  one-cycle MDU start pulse
//   ctrl_state                 RUN=0, MDU_WAIT=1, HALT=2
//   stall_cycles               saturating count of cycles with pc_en=0

module pipe_hazard_ctrl #(
   parameter int MDU_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  id_rs,
   input  logic [2:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        idex_mem_read,
   input  logic [2:0]  idex_rd,
   input  logic        ex_branch_taken,
   input  logic        id_mdu_op,
   input  logic        id_halt,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        mdu_start,
   output logic [1:0]  ctrl_state,
   output logic [15:0] stall_cycles
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MDU_WAIT = 2'd1;
   localparam logic [1:0] HALT     = 2'd2;

   // Counter runs MDU_CYCLES-1 down to 0, so MDU_WAIT lasts exactly MDU_CYCLES cycles.
   localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES - 1);

   logic [1:0] state, state_nxt;
   logic [3:0] mdu_cnt, mdu_cnt_nxt;
   logic       load_use;

   // r0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = idex_mem_read && (idex_rd != 3'd0) &&
                     ((id_use_rs && (id_rs == idex_rd)) ||
                      (id_use_rt && (id_rt == idex_rd)));

   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      mdu_start   = 1'b0;
      state_nxt   = state;
      mdu_cnt_nxt = mdu_cnt;
      // Held in reset the outputs stay at the safe stall pattern above.
      if (rst_n) begin
         case (state)
            RUN: begin
               if (ex_branch_taken) begin
                  // The IF/ID instruction is squashed, so its mdu/halt request is dropped.
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  ifid_flush = 1'b1;
               end else if (load_use) begin
                  // Hold PC and IF/ID one cycle; the bubble lets the load reach MEM.
               end else if (id_mdu_op) begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  idex_bubble = 1'b0;
                  mdu_start   = 1'b1;
                  state_nxt   = MDU_WAIT;
                  mdu_cnt_nxt = MDU_LOAD;
               end else if (id_halt) begin
                  state_nxt = HALT;
               end else begin
                  pc_en       = 1'b1;
                  ifid_en     = 1'b1;
                  idex_bubble = 1'b0;
               end
            end
            MDU_WAIT: begin
               if (mdu_cnt == 4'd0) state_nxt = RUN;
               else                 mdu_cnt_nxt = mdu_cnt - 4'd1;
            end
            HALT: begin
               // Only reset leaves HALT.
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         mdu_cnt      <= 4'd0;
         stall_cycles <= 16'd0;
      end else begin
         state   <= state_nxt;
         mdu_cnt <= mdu_cnt_nxt;
         if (!pc_en && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
      end
   end

   assign ctrl_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : directed scoreboard bench for pipe_hazard_ctrl.
// Latency : expectations are queued per cycle and checked on the following falling edge.
// Backpr. : none; the monitor pops one queued expectation every cycle.

module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic [2:0]  id_rs, id_rt, idex_rd;
   logic        id_use_rs, id_use_rt, idex_mem_read;
   logic        ex_branch_taken, id_mdu_op, id_halt;
   logic        pc_en, ifid_en, ifid_flush, idex_bubble, mdu_start;
   logic [1:0]  ctrl_state;
   logic [15:0] stall_cycles;

   pipe_hazard_ctrl #(.MDU_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
      .ex_branch_taken(ex_branch_taken),
      .id_mdu_op(id_mdu_op), .id_halt(id_halt),
      .pc_en(pc_en), .ifid_en(ifid_en),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .mdu_start(mdu_start),
      .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_en, ifid_en, ifid_flush, idex_bubble, mdu_start}
   localparam logic [4:0] O_RUN   = 5'b11000;
   localparam logic [4:0] O_STALL = 5'b00010;
   localparam logic [4:0] O_FLUSH = 5'b11110;
   localparam logic [4:0] O_MDU   = 5'b11001;

   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_MDU  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   typedef struct packed {
      logic        chk;
      logic [4:0]  outs;
      logic [1:0]  st;
      logic [15:0] stall;
   } ent_t;

   ent_t  exp_q[$];
   string name_q[$];
   int    tests = 0;
   int    fails = 0;
   logic [15:0] exp_stall = 16'd0;
   bit    stim_done = 1'b0;

   task automatic idle();
      id_rs = 3'd0; id_rt = 3'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      idex_mem_read = 1'b0; idex_rd = 3'd0;
      ex_branch_taken = 1'b0; id_mdu_op = 1'b0; id_halt = 1'b0;
   endtask

   // Queue the expected response for the current cycle, then advance one clock.
   task automatic vec(input string nm, input bit chk, input logic [4:0] eo, input logic [1:0] es);
      ent_t e;
      if (!rst_n) exp_stall = 16'd0;
      e.chk = chk; e.outs = eo; e.st = es; e.stall = exp_stall;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk); #1;
      if (rst_n && !eo[4] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
   endtask

   // Monitor: every falling edge consumes one expectation.
   initial begin
      ent_t  e;
      string nm;
      logic [22:0] act, req;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.chk) begin
               act = {pc_en, ifid_en, ifid_flush, idex_bubble, mdu_start, ctrl_state, stall_cycles};
               req = {e.outs, e.st, e.stall};
               tests++;
               if (act !== req) begin
                  fails++;
                  $display("FAIL %s: got outs=%b st=%0d stall=%h, want outs=%b st=%0d stall=%h",
                           nm, act[22:18], act[17:16], act[15:0], req[22:18], req[17:16], req[15:0]);
               end
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: stimulus did not complete, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      @(posedge clk); #1;

      vec("reset_outputs", 1, O_STALL, S_RUN);
      rst_n = 1'b1;
      vec("run_normal", 1, O_RUN, S_RUN);

      // Load-use on rs
      idex_mem_read = 1; idex_rd = 3'd3; id_rs = 3'd3; id_use_rs = 1;
      vec("load_use_rs", 1, O_STALL, S_RUN);
      idle();
      vec("after_load_use", 1, O_RUN, S_RUN);
      // Destination r0 never stalls
      idex_mem_read = 1; idex_rd = 3'd0; id_rs = 3'd0; id_use_rs = 1;
      vec("load_r0_no_stall", 1, O_RUN, S_RUN);
      // Matching rs that is not actually read
      idle(); idex_mem_read = 1; idex_rd = 3'd3; id_rs = 3'd3; id_use_rs = 0;
      vec("unused_rs_no_stall", 1, O_RUN, S_RUN);
      // Load-use on rt
      idle(); idex_mem_read = 1; idex_rd = 3'd5; id_rt = 3'd5; id_use_rt = 1; id_rs = 3'd2; id_use_rs = 1;
      vec("load_use_rt", 1, O_STALL, S_RUN);
      // Not a load: no stall
      idex_mem_read = 0;
      vec("non_load_no_stall", 1, O_RUN, S_RUN);

      // Branch wins over load-use, mdu and halt
      idle(); ex_branch_taken = 1; idex_mem_read = 1; idex_rd = 3'd4; id_rs = 3'd4; id_use_rs = 1;
      id_mdu_op = 1; id_halt = 1;
      vec("branch_priority", 1, O_FLUSH, S_RUN);
      idle();
      vec("after_branch_run", 1, O_RUN, S_RUN);

      // Load-use wins over mdu
      idex_mem_read = 1; idex_rd = 3'd1; id_rt = 3'd1; id_use_rt = 1; id_mdu_op = 1;
      vec("load_use_over_mdu", 1, O_STALL, S_RUN);

      // MDU: start pulse, exactly 8 wait cycles ignoring noise, then RUN
      idle(); id_mdu_op = 1;
      vec("mdu_start", 1, O_MDU, S_RUN);
      for (int i = 0; i < 8; i++) begin
         idle();
         ex_branch_taken = i[0];
         id_halt = i[1];
         id_mdu_op = i[2];
         vec($sformatf("mdu_wait_%0d", i), 1, O_STALL, S_MDU);
      end
      idle();
      vec("mdu_done_run", 1, O_RUN, S_RUN);

      // Reset during MDU_WAIT cycle 3: asynchronous abort
      id_mdu_op = 1;
      vec("mdu_start_2", 1, O_MDU, S_RUN);
      idle();
      vec("mdu2_wait_0", 1, O_STALL, S_MDU);
      vec("mdu2_wait_1", 1, O_STALL, S_MDU);
      rst_n = 1'b0;
      vec("async_reset_mdu", 1, O_STALL, S_RUN);
      rst_n = 1'b1;
      vec("post_reset_run", 1, O_RUN, S_RUN);

      // Halt entry, then 100 held cycles ignoring branch/mdu pulses
      id_halt = 1;
      vec("halt_entry", 1, O_STALL, S_RUN);
      idle();
      for (int i = 0; i < 100; i++) begin
         ex_branch_taken = (i % 7 == 0);
         id_mdu_op = (i % 11 == 0);
         vec("halt_hold", (i % 10 == 9), O_STALL, S_HALT);
      end
      idle();
      vec("halt_stall_101", 1, O_STALL, S_HALT);

      // Long halt: stall counter must saturate, not wrap
      for (int i = 0; i < 70000; i++)
         vec("halt_long", (i % 8192 == 0), O_STALL, S_HALT);
      vec("stall_saturated", 1, O_STALL, S_HALT);
      vec("stall_saturated_2", 1, O_STALL, S_HALT);

      // Reset leaves HALT
      rst_n = 1'b0;
      vec("async_reset_halt", 1, O_STALL, S_RUN);
      rst_n = 1'b1;
      vec("post_halt_reset_run", 1, O_RUN, S_RUN);

      @(negedge clk); @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
      end
      stim_done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_CYCLES, default 8, legal range 2..15: number of stall cycles while the multiply/divide unit executes.
REQ-002 SHALL have port clk  input  1  pipeline clock; all controller state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports id_rs, id_rt  input  3 each  source register numbers of the instruction in IF/ID.
REQ-005 SHALL have ports id_use_rs, id_use_rt  input  1 each  the IF/ID instruction actually reads rs / rt.
REQ-006 SHALL have ports idex_mem_read  input  1 and idex_rd  input  3  ID/EX instruction is a load and its destination register.
REQ-007 SHALL have port ex_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-008 SHALL have ports id_mdu_op, id_halt  input  1 each  IF/ID instruction is a multiply/divide, or a halt.
REQ-009 SHALL have ports pc_en, ifid_en  output  1 each  PC write enable and IF/ID register enable.
REQ-010 SHALL have ports ifid_flush, idex_bubble  output  1 each  clear IF/ID to NOP; insert NOP into ID/EX.
REQ-011 SHALL have port mdu_start  output  1  one-cycle start pulse to the multiply/divide unit.
REQ-012 SHALL have ports ctrl_state  output  2 (RUN=0, MDU_WAIT=1, HALT=2) and stall_cycles  output  16  saturating count of cycles with pc_en=0.

Function
REQ-013 SHALL compute all control outputs combinationally from current state and inputs so they are stable before the falling edge at which pipeline registers capture.
REQ-014 SHALL define load_use = idex_mem_read & (idex_rd != 0) & ((id_use_rs & id_rs==idex_rd) | (id_use_rt & id_rt==idex_rd)).
REQ-015 In RUN, SHALL apply priority ex_branch_taken > load_use > id_mdu_op > id_halt > normal.
REQ-016 RUN + ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1, mdu_start=0; stay RUN (a squashed mdu/halt op SHALL have no effect).
REQ-017 RUN + load_use: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0; stay RUN (exactly one bubble per load-use pair).
REQ-018 RUN + id_mdu_op: mdu_start=1, pc_en=1, ifid_en=1, no bubble; next state MDU_WAIT, down-counter loaded with MDU_CYCLES-1.
REQ-019 RUN + id_halt: pc_en=0, ifid_en=0, idex_bubble=1; next state HALT.
REQ-020 RUN, no condition: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, mdu_start=0.
REQ-021 MDU_WAIT: pc_en=0, ifid_en=0, idex_bubble=1, mdu_start=0; counter==0 -> RUN, else decrement; MDU_WAIT SHALL last exactly MDU_CYCLES cycles.
REQ-022 MDU_WAIT and HALT SHALL ignore ex_branch_taken, load_use, id_mdu_op and id_halt.
REQ-023 HALT: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0; only reset leaves HALT.
REQ-024 stall_cycles SHALL increment on each rising edge where pc_en=0 and rst_n=1, saturating at 16'hFFFF.
REQ-025 ctrl_state SHALL equal the registered state encoding.

Reset
REQ-026 rst_n=0 SHALL immediately force state=RUN, MDU counter=0, stall_cycles=0, ctrl_state=0.
REQ-027 While rst_n=0 outputs SHALL be pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1, mdu_start=0.
REQ-028 Reset asserted mid-MDU_WAIT or in HALT SHALL abort it; first cycle after release SHALL be RUN.

Verification
REQ-029 Load-use: idex_mem_read=1, idex_rd=3, id_rs=3, id_use_rs=1 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1; stall_cycles 0->1; idex_rd=0 same case -> no stall.
REQ-030 Branch vs load-use: ex_branch_taken=1 with load_use=1 and id_mdu_op=1 -> ifid_flush=1, idex_bubble=1, pc_en=1, mdu_start=0, state stays RUN.
REQ-031 MDU, MDU_CYCLES=8: id_mdu_op=1 -> mdu_start high 1 cycle, then exactly 8 cycles MDU_WAIT with pc_en=0, then RUN; stall_cycles +8.
REQ-032 Halt: id_halt=1 -> ctrl_state=2, pc_en=0 held for 100 cycles despite ex_branch_taken pulses; stall_cycles=100 (+1 entry cycle).
REQ-033 Reset mid-MDU_WAIT (cycle 3 of 8) -> outputs at reset values asynchronously; after release ctrl_state=0, stall_cycles=0, pc_en=1.
REQ-034 Saturation: hold HALT 70000 cycles -> stall_cycles=16'hFFFF, no wrap.
